// File: rtl/imem_boot_loader.sv
// Purpose     : loads a framed byte-stream program image into instruction memory, holding the core in reset until the load verifies.
// Latency     : one imem write per 4 payload bytes, strobed the cycle after the word's 4th byte is accepted.
// Backpressure: in_ready is a pure function of state; in_valid gaps simply stall the loader, there is no timeout.
//
// Ports:
//   CLK, RST             single clock, synchronous active-high reset
//   start                one-cycle pulse; starts a load from IDLE, DONE or ERROR (ignored while busy)
//   in_valid/in_ready    byte handshake; in_data is taken when both are high
//   in_data              stream byte: LEN[7:0], LEN[15:8], 4*LEN payload bytes (little-endian words), CHK
//   imem_we              one-cycle write strobe per assembled word
//   imem_addr/imem_wdata word index (from 0) and word for the write
//   core_rst             reset to the core; low only in DONE
//   busy/done/error      status decoded from the state register
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word counts are kept 17 bits wide so a full 16-bit LEN can be compared
    // against the memory depth without truncation.
    localparam int          CNT_W   = 17;
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [7:0]         len_lo;
    logic [CNT_W-1:0]   len_words;
    logic [CNT_W-1:0]   word_cnt;
    logic [1:0]         byte_cnt;
    logic [23:0]        word_buf;
    logic [7:0]         sum;

    logic               accept;
    logic               start_load;
    logic [CNT_W-1:0]   len_full;
    logic               word_last;

    // ------------------------------------------------------------------
    // Status outputs: Moore decode of the state register only.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        core_rst = 1'b1;
        case (state)
            S_LEN0, S_LEN1, S_DATA, S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            S_ERROR: begin
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign start_load = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

    // Length as it will be once the high byte currently on in_data is taken.
    assign len_full   = {1'b0, in_data, len_lo};

    // True while the word being completed is the last one of the frame.
    assign word_last  = ((word_cnt + CNT_W'(1)) == len_words);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LEN0;
            end
            S_LEN0: begin
                if (accept) next_state = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    // Lengths beyond the memory depth would wrap imem_addr.
                    if (len_full > MAX_LEN)
                        next_state = S_ERROR;
                    else if (len_full == '0)
                        next_state = S_CHECK;
                    else
                        next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt == 2'd3) && word_last) next_state = S_CHECK;
            end
            S_CHECK: begin
                if (accept) next_state = (in_data == sum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) next_state = S_LEN0;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, word assembly, checksum, memory write port.
    // Reset clears any partially assembled word and kills a pending strobe.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_lo     <= '0;
            len_words  <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            sum        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;

            if (start_load) begin
                len_lo    <= '0;
                len_words <= '0;
                word_cnt  <= '0;
                byte_cnt  <= '0;
                word_buf  <= '0;
                sum       <= '0;
            end

            case (state)
                S_LEN0: begin
                    if (accept) len_lo <= in_data;
                end
                S_LEN1: begin
                    if (accept) len_words <= len_full;
                end
                S_DATA: begin
                    if (accept) begin
                        sum      <= sum + in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word; it goes
                                // straight to the write port, not the buffer.
                                imem_we    <= 1'b1;
                                imem_wdata <= {in_data, word_buf};
                                imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                                word_cnt   <= word_cnt + CNT_W'(1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int AW = 6;

    logic          CLK;
    logic          RST;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic prev_we = 1'b0;

    // Scoreboard of expected memory writes, filled by the stimulus side.
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    logic [7:0]    frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard head.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            wr_count++;
            check("we_one_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h with empty scoreboard", imem_addr, imem_wdata);
            end else begin
                logic [AW-1:0] ea;
                logic [31:0]   ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("write_addr", {26'd0, imem_addr}, {26'd0, ea});
                check("write_data", imem_wdata, ed);
            end
        end
        prev_we = imem_we;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_write(input logic [AW-1:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input int gap);
        foreach (frame[i]) begin
            send_byte(frame[i]);
            repeat (gap) @(negedge CLK);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic load_s1(input logic [7:0] chk);
        frame = '{8'h02, 8'h00, 8'hB7, 8'h50, 8'h34, 8'h12, 8'h13, 8'h81, 8'h50, 8'h00, chk};
    endtask

    task automatic push_s1();
        push_write(6'd0, 32'h1234_50B7);
        push_write(6'd1, 32'h0050_8113);
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err,
                                input logic e_crst, input logic e_busy);
        check({tag, "_done"},     {31'd0, done},     {31'd0, e_done});
        check({tag, "_error"},    {31'd0, error},    {31'd0, e_err});
        check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, e_crst});
        check({tag, "_busy"},     {31'd0, busy},     {31'd0, e_busy});
        check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, e_busy});
    endtask

    initial begin
        int base;
        logic [7:0] s;

        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_imem_we",    {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr",  {26'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: two-word load
        push_s1();
        pulse_start();
        check("s1_busy_after_start", {31'd0, busy}, 32'd1);
        load_s1(8'h31);
        send_frame(0);
        check_status("s1", 1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_pending", exp_addr_q.size(), 32'd0);

        // 2: bad checksum, then reload from ERROR
        push_s1();
        pulse_start();
        check("s2_core_rst_on_start", {31'd0, core_rst}, 32'd1);
        load_s1(8'h32);
        send_frame(0);
        check_status("s2_bad", 1'b0, 1'b1, 1'b1, 1'b0);
        check("s2_pending", exp_addr_q.size(), 32'd0);
        push_s1();
        pulse_start();
        load_s1(8'h31);
        send_frame(0);
        check_status("s2_reload", 1'b1, 1'b0, 1'b0, 1'b0);

        // 3a: empty image
        base = wr_count;
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_status("s3_empty", 1'b1, 1'b0, 1'b0, 1'b0);
        check("s3_no_writes", wr_count - base, 32'd0);

        // 3b: LEN = 65 exceeds 64-word memory
        pulse_start();
        frame = '{8'h41, 8'h00};
        send_frame(0);
        check_status("s3_toolong", 1'b0, 1'b1, 1'b1, 1'b0);

        // 3c: LEN = 0x0100, rejected through the high byte
        pulse_start();
        frame = '{8'h00, 8'h01};
        send_frame(0);
        check_status("s3_hibyte", 1'b0, 1'b1, 1'b1, 1'b0);

        // 4: in_valid gaps of 3 cycles
        base = wr_count;
        push_s1();
        pulse_start();
        load_s1(8'h31);
        send_frame(3);
        check_status("s4", 1'b1, 1'b0, 1'b0, 1'b0);
        check("s4_write_count", wr_count - base, 32'd2);

        // 5: reset after payload byte 6; start coincident with reset is ignored
        push_write(6'd0, 32'h1234_50B7);
        pulse_start();
        frame = '{8'h02, 8'h00, 8'hB7, 8'h50, 8'h34, 8'h12, 8'h13, 8'h81};
        send_frame(0);
        RST   = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        RST   = 1'b0;
        start = 1'b0;
        check_status("s5_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge CLK);
        check("s5_imem_we_quiet", {31'd0, imem_we}, 32'd0);
        check("s5_pending", exp_addr_q.size(), 32'd0);

        // 5b: start during DATA must not disturb the load
        push_s1();
        pulse_start();
        frame = '{8'h02, 8'h00, 8'hB7, 8'h50};
        send_frame(0);
        pulse_start();
        check("s5b_busy", {31'd0, busy}, 32'd1);
        frame = '{8'h34, 8'h12, 8'h13, 8'h81, 8'h50, 8'h00, 8'h31};
        send_frame(0);
        check_status("s5b", 1'b1, 1'b0, 1'b0, 1'b0);

        // 6: full-depth load, word i = i * 0x01010101
        base = wr_count;
        s = 8'h00;
        frame = '{8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            push_write(AW'(i), 32'(i) * 32'h0101_0101);
            for (int k = 0; k < 4; k++) begin
                frame.push_back(8'(i));
                s = s + 8'(i);
            end
        end
        frame.push_back(s);
        check("s6_chk_value", {24'd0, s}, 32'h80);
        pulse_start();
        send_frame(0);
        check_status("s6", 1'b1, 1'b0, 1'b0, 1'b0);
        check("s6_write_count", wr_count - base, 32'd64);
        check("s6_pending", exp_addr_q.size(), 32'd0);

        repeat (4) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
